// File: rtl/frame_pulse_gen.sv
// Frame pulse generator.
// Counts CLK cycles within a programmable frame. SYNC_OUT is high for the
// first W cycles of every frame. TR_OUT is high for one cycle at offset T.
// New timing is loaded through a strobe into pending registers, and it only
// becomes active at a frame boundary.
//
// Config handshake: CFG_LOAD is a single-cycle strobe that is always accepted.
// No ready is needed. CFG_ACK is high for exactly the cycle after each strobe
// that was sampled with CLR low.
module frame_pulse_gen #(
  parameter int DEF_PERIOD = 26250,
  parameter int DEF_WIDTH  = 1,
  parameter int DEF_TRIG   = 20853
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        EN,
  input  logic        CFG_LOAD,
  input  logic [15:0] CFG_PERIOD,
  input  logic [15:0] CFG_WIDTH,
  input  logic [15:0] CFG_TRIG,
  output logic        CFG_ACK,
  output logic        SYNC_OUT,
  output logic        TR_OUT,
  output logic [15:0] CNT,
  output logic [7:0]  FRAME_CNT,
  output logic        STATE_DBG
);

  // Reset configuration, clamped with the same rules as a runtime load.
  localparam logic [15:0] DEF_P = (DEF_PERIOD < 2) ? 16'd2 : 16'(DEF_PERIOD);
  localparam logic [15:0] DEF_W = (16'(DEF_WIDTH) >= DEF_P) ? DEF_P - 16'd1
                                                            : 16'(DEF_WIDTH);
  localparam logic [15:0] DEF_T = 16'(DEF_TRIG);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic        sync_q, sync_d;
  logic        tr_q, tr_d;
  logic        ack_q, ack_d;
  logic [15:0] per_q, per_d;
  logic [15:0] wid_q, wid_d;
  logic [15:0] trg_q, trg_d;
  logic [15:0] pper_q, pper_d;
  logic [15:0] pwid_q, pwid_d;
  logic [15:0] ptrg_q, ptrg_d;
  logic        pend_q, pend_d;
  logic        frame_start;
  logic [15:0] app_per;
  logic [15:0] app_wid;

  // The state register.
  always_ff @(posedge CLK) begin
    if (CLR) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, frame position, and config application at frame starts.
  always_comb begin
    state_d     = EN ? RUN : IDLE;
    frame_start = 1'b0;
    cnt_d       = 16'd0;
    fcnt_d      = fcnt_q;
    per_d       = per_q;
    wid_d       = wid_q;
    trg_d       = trg_q;
    pper_d      = pper_q;
    pwid_d      = pwid_q;
    ptrg_d      = ptrg_q;
    pend_d      = pend_q;
    ack_d       = CFG_LOAD;
    app_per     = (pper_q < 16'd2) ? 16'd2 : pper_q;
    app_wid     = (pwid_q >= app_per) ? app_per - 16'd1 : pwid_q;

    if (EN) begin
      frame_start = (state_q == IDLE) || (cnt_q == per_q - 16'd1);
      if (frame_start) begin
        cnt_d  = 16'd0;
        fcnt_d = fcnt_q + 8'd1;
        if (pend_q) begin
          per_d  = app_per;
          wid_d  = app_wid;
          trg_d  = ptrg_q;
          pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    // A load on a frame-start edge lands after the old pending set is applied.
    if (CFG_LOAD) begin
      pper_d = CFG_PERIOD;
      pwid_d = CFG_WIDTH;
      ptrg_d = CFG_TRIG;
      pend_d = 1'b1;
    end

    sync_d = (state_d == RUN) && (cnt_d < wid_d);
    tr_d   = (state_d == RUN) && (cnt_d == trg_d) && (trg_d < per_d);
  end

  // Registers for the datapath, the outputs and the config.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      cnt_q  <= 16'd0;
      fcnt_q <= 8'd0;
      sync_q <= 1'b0;
      tr_q   <= 1'b0;
      ack_q  <= 1'b0;
      per_q  <= DEF_P;
      wid_q  <= DEF_W;
      trg_q  <= DEF_T;
      pper_q <= 16'd0;
      pwid_q <= 16'd0;
      ptrg_q <= 16'd0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      fcnt_q <= fcnt_d;
      sync_q <= sync_d;
      tr_q   <= tr_d;
      ack_q  <= ack_d;
      per_q  <= per_d;
      wid_q  <= wid_d;
      trg_q  <= trg_d;
      pper_q <= pper_d;
      pwid_q <= pwid_d;
      ptrg_q <= ptrg_d;
      pend_q <= pend_d;
    end
  end

  assign CFG_ACK   = ack_q;
  assign SYNC_OUT  = sync_q;
  assign TR_OUT    = tr_q;
  assign CNT       = cnt_q;
  assign FRAME_CNT = fcnt_q;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_frame_pulse_gen.sv
// Bench for frame_pulse_gen.
// A driver applies one input vector per cycle and advances a frame-level
// reference model. The expected outputs for the following cycle are pushed
// into a queue. A monitor pops one entry after each rising edge and compares
// it with the DUT outputs.
module tb_frame_pulse_gen;

  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic        EN = 1'b0;
  logic        CFG_LOAD = 1'b0;
  logic [15:0] CFG_PERIOD = 16'd0;
  logic [15:0] CFG_WIDTH = 16'd0;
  logic [15:0] CFG_TRIG = 16'd0;
  logic        CFG_ACK;
  logic        SYNC_OUT;
  logic        TR_OUT;
  logic [15:0] CNT;
  logic [7:0]  FRAME_CNT;
  logic        STATE_DBG;

  frame_pulse_gen dut (
    .CLK(CLK), .CLR(CLR), .EN(EN), .CFG_LOAD(CFG_LOAD),
    .CFG_PERIOD(CFG_PERIOD), .CFG_WIDTH(CFG_WIDTH), .CFG_TRIG(CFG_TRIG),
    .CFG_ACK(CFG_ACK), .SYNC_OUT(SYNC_OUT), .TR_OUT(TR_OUT),
    .CNT(CNT), .FRAME_CNT(FRAME_CNT), .STATE_DBG(STATE_DBG)
  );

  // Clock generation.
  always #5 CLK = ~CLK;

  // Scoreboard state: {ack, sync, tr, cnt[15:0], frame_cnt[7:0]}.
  logic [26:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference model: running flag, position, frame count, active config, and
  // at most one pending config.
  bit m_run = 0;
  int m_cnt = 0;
  int m_fc  = 0;
  int m_p = 26250, m_w = 1, m_t = 20853;
  bit m_pv = 0;
  int m_pp = 0, m_pw = 0, m_pt = 0;

  task automatic drive(input bit clr, input bit en, input bit ld,
                       input int p, input int w, input int t);
    bit ack, sync, tr;
    @(negedge CLK);
    CLR = clr; EN = en; CFG_LOAD = ld;
    CFG_PERIOD = 16'(p); CFG_WIDTH = 16'(w); CFG_TRIG = 16'(t);
    if (clr) begin
      m_run = 0; m_cnt = 0; m_fc = 0; m_pv = 0;
      m_p = 26250; m_w = 1; m_t = 20853;
      ack = 0;
    end else begin
      ack = ld;
      if (en) begin
        if (!m_run || m_cnt == m_p - 1) begin
          m_cnt = 0;
          m_fc = (m_fc + 1) % 256;
          if (m_pv) begin
            m_p = (m_pp < 2) ? 2 : m_pp;
            m_w = (m_pw >= m_p) ? m_p - 1 : m_pw;
            m_t = m_pt;
            m_pv = 0;
          end
        end else begin
          m_cnt = m_cnt + 1;
        end
        m_run = 1;
      end else begin
        m_run = 0;
        m_cnt = 0;
      end
      if (ld) begin
        m_pp = p & 16'hffff; m_pw = w & 16'hffff; m_pt = t & 16'hffff;
        m_pv = 1;
      end
    end
    sync = m_run && (m_cnt < m_w);
    tr   = m_run && (m_cnt == m_t) && (m_t < m_p);
    exp_q.push_back({ack, sync, tr, 16'(m_cnt), 8'(m_fc)});
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) drive(0, 1, 0, 0, 0, 0);
  endtask

  // Run until the model position reaches c. Returns early if the bound expires.
  task automatic run_until_cnt(input int c, input int limit);
    int k = 0;
    while (!(m_run && m_cnt == c) && k < limit) begin
      drive(0, 1, 0, 0, 0, 0);
      k++;
    end
    if (k >= limit) begin
      n_cmp++; n_err++;
      $display("FAIL wait_cnt: position %0d not reached, stuck at %0d", c, m_cnt);
    end
  endtask

  // Monitor: compares one expected entry per cycle against the DUT outputs.
  initial begin
    logic [26:0] e, a;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {CFG_ACK, SYNC_OUT, TR_OUT, CNT, FRAME_CNT};
        n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL out_chk t=%0t got ack=%0b sync=%0b tr=%0b cnt=%0d fc=%0d, expected ack=%0b sync=%0b tr=%0b cnt=%0d fc=%0d",
                   $time, a[26], a[25], a[24], a[23:8], a[7:0],
                   e[26], e[25], e[24], e[23:8], e[7:0]);
        end
      end
    end
  end

  // Stimulus sequence.
  initial begin
    // Reset state.
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 9, 9, 9);
    drive(0, 0, 0, 0, 0, 0);

    // Run a full default frame past its wrap.
    run_cycles(26250 + 40);

    // Mid-frame load of 10/3/7. The old timing holds to the end of the frame.
    drive(0, 1, 1, 10, 3, 7);
    run_cycles(26250);
    run_cycles(25);

    // Degenerate load: period 1 and width 5 clamp to 2 and 1, and trigger 12
    // is suppressed.
    drive(0, 1, 1, 1, 5, 12);
    run_cycles(30);

    // A pending load, then a second load on the wrap edge.
    drive(0, 1, 1, 6, 2, 3);
    run_until_cnt(1, 20);
    run_until_cnt(0, 20);
    run_until_cnt(5, 20);
    drive(0, 1, 1, 8, 4, 6);
    run_cycles(30);

    // Drop EN at position 5 for three cycles, then restart.
    run_until_cnt(5, 20);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    run_cycles(20);

    // Assert CLR mid-frame with a load pending. Defaults return.
    drive(0, 1, 1, 3, 1, 1);
    drive(1, 1, 0, 0, 0, 0);
    run_cycles(12);
    drive(0, 0, 1, 2, 1, 1);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 2, 1, 1);
    run_cycles(512 + 3);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 19) != 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 12), $urandom_range(0, 14), $urandom_range(0, 14));
    end
    drive(0, 0, 0, 0, 0, 0);

    // Let the monitor drain, then require an empty queue.
    @(posedge CLK);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
